// File: rtl/vdp_pkg.sv
// Shared constants for the VDP alpha-blend pipeline: widths, ARGB field offsets,
// layer one-hot codes and the fixed blend latency.
package vdp_pkg;

  localparam int CH_BITS       = 4;
  localparam int ENTRY_BITS    = 4 * CH_BITS;
  localparam int RGB_BITS      = 3 * CH_BITS;
  localparam int INDEX_BITS    = 8;
  localparam int LAYER_BITS    = 5;
  localparam int BLEND_LATENCY = 3;

  // Palette entries are packed {A,R,G,B}, blue in the least significant channel
  localparam int BLUE_OFS  = 0;
  localparam int GREEN_OFS = CH_BITS;
  localparam int RED_OFS   = 2 * CH_BITS;
  localparam int ALPHA_OFS = 3 * CH_BITS;

  localparam logic [LAYER_BITS-1:0] LAYER_NONE    = 5'b00000;
  localparam logic [LAYER_BITS-1:0] LAYER_SCROLL0 = 5'b00001;
  localparam logic [LAYER_BITS-1:0] LAYER_SCROLL1 = 5'b00010;
  localparam logic [LAYER_BITS-1:0] LAYER_SCROLL2 = 5'b00100;
  localparam logic [LAYER_BITS-1:0] LAYER_SCROLL3 = 5'b01000;
  localparam logic [LAYER_BITS-1:0] LAYER_SPRITE  = 5'b10000;

endpackage

// File: rtl/vdp_alpha_blend_pipeline_if.sv
// Pixel stream, palette write handshake and blended output of the blend stage.
interface vdp_alpha_blend_pipeline_if;
  import vdp_pkg::*;

  logic                  pixel_valid;
  logic [INDEX_BITS-1:0] primary_pixel;
  logic [LAYER_BITS-1:0] primary_layer;
  logic [INDEX_BITS-1:0] masked_pixel;
  logic [LAYER_BITS-1:0] masked_layer;
  logic [RGB_BITS-1:0]   background_color;
  logic                  pal_write_req;
  logic [INDEX_BITS-1:0] pal_write_addr;
  logic [ENTRY_BITS-1:0] pal_write_data;
  logic                  pal_write_ready;
  logic                  out_valid;
  logic [RGB_BITS-1:0]   out_rgb;
  logic [LAYER_BITS-1:0] out_layer;

  modport master (
    output pixel_valid, primary_pixel, primary_layer, masked_pixel, masked_layer,
           background_color, pal_write_req, pal_write_addr, pal_write_data,
    input  pal_write_ready, out_valid, out_rgb, out_layer
  );

  modport slave (
    input  pixel_valid, primary_pixel, primary_layer, masked_pixel, masked_layer,
           background_color, pal_write_req, pal_write_addr, pal_write_data,
    output pal_write_ready, out_valid, out_rgb, out_layer
  );

endinterface

// File: rtl/vdp_palette_ram.sv
// Single-write, single-read palette memory with a registered read port.
module vdp_palette_ram #(
  parameter int    DEPTH     = 256,
  parameter int    WIDTH     = 16,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left out of reset so the palette survives a pipeline flush
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vdp_alpha_blend_pipeline.sv
// Three-stage palette lookup and alpha-over blend: palette read, weight/products, sum and output.
module vdp_alpha_blend_pipeline
  import vdp_pkg::*;
#(
  parameter int    PALETTE_DEPTH = 256,
  parameter int    CHANNEL_BITS  = CH_BITS,
  parameter string INIT_FILE     = ""
) (
  input logic                       clk,
  input logic                       reset,
  vdp_alpha_blend_pipeline_if.slave bus
);

  localparam int ADDR_W   = (PALETTE_DEPTH > 1) ? $clog2(PALETTE_DEPTH) : 1;
  localparam int CB       = CHANNEL_BITS;
  localparam int ENTRY_W  = 4 * CB;
  localparam int RGB_W    = 3 * CB;
  localparam int WEIGHT_W = CB + 1;
  localparam int PROD_W   = 2 * CB + 1;
  localparam logic [WEIGHT_W-1:0] FULL_WEIGHT = WEIGHT_W'(1 << CB);

  function automatic logic [ADDR_W-1:0] wrap_index(input logic [INDEX_BITS-1:0] idx);
    return ADDR_W'(int'(idx) % PALETTE_DEPTH);
  endfunction

  logic              write_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [ENTRY_W-1:0] rd_data [2];

  assign bus.pal_write_ready = ~bus.pixel_valid;
  assign write_en   = bus.pal_write_req & bus.pal_write_ready;
  assign wr_addr    = wrap_index(bus.pal_write_addr);
  assign rd_addr[0] = wrap_index(bus.primary_pixel);
  assign rd_addr[1] = wrap_index(bus.masked_pixel);

  // Copy 0 serves the primary index, copy 1 the alpha-over index; both take every write
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pal
      vdp_palette_ram #(
        .DEPTH(PALETTE_DEPTH), .WIDTH(ENTRY_W), .ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)
      ) u_ram (
        .clk(clk), .we(write_en), .waddr(wr_addr), .wdata(bus.pal_write_data),
        .raddr(rd_addr[gi]), .rdata(rd_data[gi])
      );
    end
  endgenerate

  logic                  s1_valid_reg, s1_masked_on_reg;
  logic [LAYER_BITS-1:0] s1_layer_reg;
  logic [RGB_W-1:0]      s1_background_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg      <= 1'b0;
      s1_masked_on_reg  <= 1'b0;
      s1_layer_reg      <= '0;
      s1_background_reg <= '0;
    end else begin
      s1_valid_reg      <= bus.pixel_valid;
      s1_masked_on_reg  <= |bus.masked_layer;
      s1_layer_reg      <= bus.primary_layer;
      s1_background_reg <= bus.background_color;
    end
  end

  logic [CB-1:0]       masked_alpha;
  logic [WEIGHT_W-1:0] weight, inv_weight;
  logic                unused_primary_alpha;

  // The primary winner is always opaque, so its own alpha nibble is ignored
  assign unused_primary_alpha = ^rd_data[0][3*CB +: CB];
  assign masked_alpha = rd_data[1][3*CB +: CB];
  assign inv_weight   = FULL_WEIGHT - weight;

  always_comb begin
    weight = '0;
    if (s1_masked_on_reg) begin
      weight = (&masked_alpha) ? FULL_WEIGHT : WEIGHT_W'(masked_alpha);
    end
  end

  logic [PROD_W-1:0]     prod_p_next [3], prod_m_next [3], blend_sum [3];
  logic [PROD_W-1:0]     s2_prod_p_reg [3], s2_prod_m_reg [3];
  logic                  s2_valid_reg;
  logic [LAYER_BITS-1:0] s2_layer_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [CB-1:0] prim_ch, mask_ch;
      assign prim_ch = (|s1_layer_reg) ? rd_data[0][gi*CB +: CB] : s1_background_reg[gi*CB +: CB];
      assign mask_ch = rd_data[1][gi*CB +: CB];
      assign prod_p_next[gi] = PROD_W'(prim_ch) * PROD_W'(inv_weight);
      assign prod_m_next[gi] = PROD_W'(mask_ch) * PROD_W'(weight);
      assign blend_sum[gi]   = s2_prod_p_reg[gi] + s2_prod_m_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_layer_reg <= '0;
      for (int i = 0; i < 3; i++) begin
        s2_prod_p_reg[i] <= '0;
        s2_prod_m_reg[i] <= '0;
      end
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_layer_reg <= s1_layer_reg;
      for (int i = 0; i < 3; i++) begin
        s2_prod_p_reg[i] <= prod_p_next[i];
        s2_prod_m_reg[i] <= prod_m_next[i];
      end
    end
  end

  // Weights sum to 16, so the shifted sum never exceeds a channel and needs no clamp
  logic [RGB_W-1:0] out_rgb_next;
  always_comb begin
    out_rgb_next = '0;
    for (int i = 0; i < 3; i++) begin
      out_rgb_next[i*CB +: CB] = CB'(blend_sum[i] >> CB);
    end
  end

  logic                  out_valid_reg;
  logic [RGB_W-1:0]      out_rgb_reg;
  logic [LAYER_BITS-1:0] out_layer_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_rgb_reg   <= '0;
      out_layer_reg <= '0;
    end else begin
      out_valid_reg <= s2_valid_reg;
      out_rgb_reg   <= out_rgb_next;
      out_layer_reg <= s2_layer_reg;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_rgb   = out_rgb_reg;
  assign bus.out_layer = out_layer_reg;

endmodule

// File: tb/tb_vdp_alpha_blend_pipeline.sv
// Randomised and directed bench for the alpha-blend pipeline against a palette/blend reference model.
module tb_vdp_alpha_blend_pipeline;
  import vdp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vdp_alpha_blend_pipeline_if bus ();

  vdp_alpha_blend_pipeline #(
    .PALETTE_DEPTH(256), .CHANNEL_BITS(4), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit          v;
    logic [11:0] rgb;
    logic [4:0]  layer;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pal_model [256];
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_px    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_blend(input logic [7:0] pi, input logic [4:0] pl,
                                            input logic [7:0] mi, input logic [4:0] ml,
                                            input logic [11:0] bg);
    int a, w, p, m;
    logic [15:0] pe, me;
    logic [11:0] r;
    pe = pal_model[pi];
    me = pal_model[mi];
    a  = int'(me[15:12]);
    w  = (ml == 0) ? 0 : ((a == 15) ? 16 : a);
    r  = '0;
    for (int c = 0; c < 3; c++) begin
      p = (pl != 0) ? int'(pe[4*c +: 4]) : int'(bg[4*c +: 4]);
      m = int'(me[4*c +: 4]);
      r[4*c +: 4] = 4'((p * (16 - w) + m * w) / 16);
    end
    return r;
  endfunction

  function automatic logic [4:0] rand_layer();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? LAYER_NONE : 5'(1 << r);
  endfunction

  // One pixel per call: starts and ends 1 time unit after a rising edge
  task automatic step(input bit v, input logic [7:0] pi, input logic [4:0] pl,
                      input logic [7:0] mi, input logic [4:0] ml, input logic [11:0] bg,
                      input int want = -1);
    exp_t e;
    bit   commit;
    bus.pixel_valid      = v;
    bus.primary_pixel    = pi;
    bus.primary_layer    = pl;
    bus.masked_pixel     = mi;
    bus.masked_layer     = ml;
    bus.background_color = bg;
    e.v     = v;
    e.layer = pl;
    e.rgb   = (want >= 0) ? 12'(want) : ref_blend(pi, pl, mi, ml, bg);
    exp_q.push_back(e);
    #1;
    check("ready", {31'b0, bus.pal_write_ready}, {31'b0, !v});
    commit = bus.pal_write_req && !v;
    @(posedge clk);
    #1;
    if (commit) begin
      pal_model[bus.pal_write_addr] = bus.pal_write_data;
      bus.pal_write_req = 1'b0;
    end
    if (exp_q.size() >= BLEND_LATENCY) begin
      e = exp_q.pop_front();
      n_px++;
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, e.v});
      check("out_layer", {27'b0, bus.out_layer}, {27'b0, e.layer});
      if (e.v) check("out_rgb", {20'b0, bus.out_rgb}, {20'b0, e.rgb});
      $display("px %0d v=%0b rgb=%03h layer=%05b exp_rgb=%03h", n_px, bus.out_valid,
               bus.out_rgb, bus.out_layer, e.rgb);
    end else begin
      check("idle_valid", {31'b0, bus.out_valid}, 32'd0);
    end
  endtask

  task automatic write_entry(input logic [7:0] addr, input logic [15:0] data);
    bus.pal_write_req  = 1'b1;
    bus.pal_write_addr = addr;
    bus.pal_write_data = data;
    step(1'b0, 8'h00, LAYER_NONE, 8'h00, LAYER_NONE, 12'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    bus.pixel_valid      = 1'b0;
    bus.primary_pixel    = '0;
    bus.primary_layer    = '0;
    bus.masked_pixel     = '0;
    bus.masked_layer     = '0;
    bus.background_color = '0;
    bus.pal_write_req    = 1'b0;
    bus.pal_write_addr   = '0;
    bus.pal_write_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_rgb", {20'b0, bus.out_rgb}, 32'd0);
    check("rst_out_layer", {27'b0, bus.out_layer}, 32'd0);
    check("rst_ready", {31'b0, bus.pal_write_ready}, 32'd1);
    reset = 1'b0;

    // Fill the whole palette so every index has a known value, then the directed entries
    for (int i = 0; i < 256; i++) write_entry(8'(i), 16'($urandom));
    write_entry(8'h12, 16'hFA53);
    write_entry(8'h34, 16'h80F0);
    write_entry(8'h50, 16'hF777);
    write_entry(8'h51, 16'h0777);

    step(1'b1, 8'h12, LAYER_SCROLL0, 8'h00, LAYER_NONE, 12'hFFF, 12'hA53);
    step(1'b1, 8'h34, LAYER_SCROLL1, 8'h00, LAYER_NONE, 12'hFFF, 12'h0F0);
    step(1'b1, 8'h12, LAYER_SCROLL0, 8'h34, LAYER_SPRITE, 12'h000, 12'h5A1);
    step(1'b1, 8'h99, LAYER_NONE, 8'h50, LAYER_SPRITE, 12'h123, 12'h777);
    step(1'b1, 8'h99, LAYER_NONE, 8'h51, LAYER_SPRITE, 12'h123, 12'h123);
    step(1'b1, 8'h99, LAYER_NONE, 8'h50, LAYER_NONE, 12'h123, 12'h123);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] ml;
      if (!bus.pal_write_req && $urandom_range(0, 7) == 0) begin
        bus.pal_write_req  = 1'b1;
        bus.pal_write_addr = 8'($urandom);
        bus.pal_write_data = 16'($urandom);
      end
      ml = ($urandom_range(0, 2) == 0) ? LAYER_NONE : rand_layer();
      step($urandom_range(0, 9) != 0, 8'($urandom), rand_layer(), 8'($urandom), ml,
           12'($urandom));
    end
    bus.pal_write_req = 1'b0;

    // Write held through active display must not land until blanking
    bus.pal_write_req  = 1'b1;
    bus.pal_write_addr = 8'h34;
    bus.pal_write_data = 16'h39C6;
    for (int i = 0; i < 10; i++) step(1'b1, 8'h34, LAYER_SCROLL2, 8'h00, LAYER_NONE, 12'h000, 12'h0F0);
    check("req_still_pending", {31'b0, bus.pal_write_req}, 32'd1);
    step(1'b0, 8'h00, LAYER_NONE, 8'h00, LAYER_NONE, 12'h000);
    check("req_accepted", {31'b0, bus.pal_write_req}, 32'd0);
    step(1'b1, 8'h34, LAYER_SCROLL2, 8'h00, LAYER_NONE, 12'h000, 12'h9C6);

    for (int i = 0; i < 5; i++) step(1'b1, 8'h12, LAYER_SCROLL3, 8'h00, LAYER_NONE, 12'h000, 12'hA53);
    bus.pixel_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_rgb", {20'b0, bus.out_rgb}, 32'd0);
    check("midrst_layer", {27'b0, bus.out_layer}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    step(1'b0, 8'h00, LAYER_NONE, 8'h00, LAYER_NONE, 12'h000);
    step(1'b1, 8'h12, LAYER_SCROLL0, 8'h34, LAYER_SPRITE, 12'h000);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, LAYER_NONE, 8'h00, LAYER_NONE, 12'h000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
